timer_alarm_core: RTL and testbench



---
 rtl/timer_alarm_core.sv | 97 +++++++++
 tb/tb_timer_alarm_core.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_alarm_core.sv
// Programmable countdown alarm: loads a 2*DATA_W-bit count, decrements while enabled,
// and raises a sticky IRQ (plus OVERRUN for unacknowledged repeats) at terminal count.
module timer_alarm_core #(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ALARM_LOAD,
   input  logic [DATA_W-1:0]   ALARM_LOAD_LOW,
   input  logic [DATA_W-1:0]   ALARM_LOAD_HIGH,
   input  logic                ALARM_ENABLE,
   input  logic                ALARM_PERIODIC,
   input  logic                ALARM_ACK,
   output logic                ALARM_IRQ,
   output logic                ALARM_OVERRUN,
   output logic                ALARM_BUSY,
   output logic [2*DATA_W-1:0] ALARM_REMAIN,
   output logic [1:0]          alarm_state
);

   localparam int CW = 2 * DATA_W;

   // Encoding is visible on alarm_state: IDLE=0, ARMED=1, RUN=2, DONE=3.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, reload_q;
   logic [CW-1:0] load_val;
   logic          active, tick, expire;
   logic          irq_q, ovr_q;

   assign load_val = {ALARM_LOAD_HIGH, ALARM_LOAD_LOW};
   assign active   = (state_q == S_ARMED) || (state_q == S_RUN);
   // A load in the same cycle pre-empts any decrement or expiry.
   assign tick     = active && ALARM_ENABLE && !ALARM_LOAD;
   assign expire   = tick && (count_q == CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ALARM_LOAD) begin
         if (load_val == '0)    state_d = S_IDLE;
         else if (ALARM_ENABLE) state_d = S_RUN;
         else                   state_d = S_ARMED;
      end else if (active) begin
         if (expire && !ALARM_PERIODIC) state_d = S_DONE;
         else if (ALARM_ENABLE)         state_d = S_RUN;
         else                           state_d = S_ARMED;
      end
   end

   always_comb begin
      ALARM_BUSY  = active;
      alarm_state = state_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         reload_q <= '0;
      end else if (ALARM_LOAD) begin
         count_q  <= load_val;
         reload_q <= load_val;
      end else if (expire) begin
         count_q  <= ALARM_PERIODIC ? reload_q : '0;
      end else if (tick) begin
         count_q  <= count_q - CW'(1);
      end
   end

   // ACK is applied before a coincident expiry, so the expiry re-sets IRQ but not OVERRUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         if (expire)         irq_q <= 1'b1;
         else if (ALARM_ACK) irq_q <= 1'b0;
         if (ALARM_ACK)               ovr_q <= 1'b0;
         else if (expire && irq_q)    ovr_q <= 1'b1;
      end
   end

   assign ALARM_IRQ     = irq_q;
   assign ALARM_OVERRUN = ovr_q;
   assign ALARM_REMAIN  = count_q;

endmodule

// File: tb/tb_timer_alarm_core.sv
// Bench for timer_alarm_core: directed literal scenarios followed by random traffic,
// all checked every cycle against a behavioural model of the alarm rules.
module tb_timer_alarm_core;

   localparam int DATA_W = 32;

   localparam logic [1:0] M_IDLE  = 2'd0;
   localparam logic [1:0] M_ARMED = 2'd1;
   localparam logic [1:0] M_RUN   = 2'd2;
   localparam logic [1:0] M_DONE  = 2'd3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              ALARM_LOAD = 1'b0;
   logic [DATA_W-1:0] ALARM_LOAD_LOW = '0;
   logic [DATA_W-1:0] ALARM_LOAD_HIGH = '0;
   logic              ALARM_ENABLE = 1'b0;
   logic              ALARM_PERIODIC = 1'b0;
   logic              ALARM_ACK = 1'b0;
   logic              ALARM_IRQ;
   logic              ALARM_OVERRUN;
   logic              ALARM_BUSY;
   logic [63:0]       ALARM_REMAIN;
   logic [1:0]        alarm_state;

   int n_checks = 0;
   int n_errors = 0;

   timer_alarm_core #(.DATA_W(DATA_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ALARM_LOAD     (ALARM_LOAD),
      .ALARM_LOAD_LOW (ALARM_LOAD_LOW),
      .ALARM_LOAD_HIGH(ALARM_LOAD_HIGH),
      .ALARM_ENABLE   (ALARM_ENABLE),
      .ALARM_PERIODIC (ALARM_PERIODIC),
      .ALARM_ACK      (ALARM_ACK),
      .ALARM_IRQ      (ALARM_IRQ),
      .ALARM_OVERRUN  (ALARM_OVERRUN),
      .ALARM_BUSY     (ALARM_BUSY),
      .ALARM_REMAIN   (ALARM_REMAIN),
      .alarm_state    (alarm_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [63:0] cnt;
      logic [63:0] reload;
      logic [1:0]  mode;
      logic        irq;
      logic        ovr;
   } model_t;

   model_t m;

   function automatic model_t model_next(input model_t cur, input logic ld,
                                         input logic [63:0] val, input logic en,
                                         input logic per, input logic ack);
      model_t n = cur;
      if (ack) begin
         n.irq = 1'b0;
         n.ovr = 1'b0;
      end
      if (ld) begin
         if (val == 64'd0) begin
            n.cnt  = 64'd0;
            n.mode = M_IDLE;
         end else begin
            n.cnt    = val;
            n.reload = val;
            n.mode   = en ? M_RUN : M_ARMED;
         end
      end else if (cur.mode == M_ARMED || cur.mode == M_RUN) begin
         if (!en) begin
            n.mode = M_ARMED;
         end else if (cur.cnt == 64'd1) begin
            if (n.irq) n.ovr = 1'b1;
            n.irq = 1'b1;
            if (per) begin
               n.cnt  = cur.reload;
               n.mode = M_RUN;
            end else begin
               n.cnt  = 64'd0;
               n.mode = M_DONE;
            end
         end else begin
            n.cnt  = cur.cnt - 64'd1;
            n.mode = M_RUN;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else m <= model_next(m, ALARM_LOAD, {ALARM_LOAD_HIGH, ALARM_LOAD_LOW},
                           ALARM_ENABLE, ALARM_PERIODIC, ALARM_ACK);
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         check("model_remain",  ALARM_REMAIN,              m.cnt);
         check("model_irq",     64'(ALARM_IRQ),            64'(m.irq));
         check("model_overrun", 64'(ALARM_OVERRUN),        64'(m.ovr));
         check("model_busy",    64'(ALARM_BUSY),           64'(m.mode == M_ARMED || m.mode == M_RUN));
         check("model_state",   64'(alarm_state),          64'(m.mode));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_load(input logic [63:0] v);
      ALARM_LOAD = 1'b1;
      {ALARM_LOAD_HIGH, ALARM_LOAD_LOW} = v;
      @(negedge clk);
      ALARM_LOAD = 1'b0;
   endtask

   task automatic do_ack();
      ALARM_ACK = 1'b1;
      @(negedge clk);
      ALARM_ACK = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #1 rst_n = 1'b0;
      step(2);
      check("reset_remain", ALARM_REMAIN, 64'd0);
      check("reset_irq",    64'(ALARM_IRQ),  64'd0);
      check("reset_busy",   64'(ALARM_BUSY), 64'd0);
      rst_n = 1'b1;
      step(1);

      // One-shot load of 5: 5,4,3,2,1,0 then DONE with IRQ held.
      ALARM_ENABLE = 1'b1;
      ALARM_PERIODIC = 1'b0;
      do_load(64'd5);
      check("os_remain0", ALARM_REMAIN, 64'd5);
      for (int j = 1; j <= 5; j++) begin
         step(1);
         check("os_remain", ALARM_REMAIN, 64'(5 - j));
         check("os_irq",    64'(ALARM_IRQ), 64'(j == 5));
      end
      check("os_busy_done",  64'(ALARM_BUSY),  64'd0);
      check("os_state_done", 64'(alarm_state), 64'(M_DONE));
      step(3);
      check("os_irq_hold", 64'(ALARM_IRQ), 64'd1);
      do_ack();
      check("os_irq_acked", 64'(ALARM_IRQ), 64'd0);

      // Periodic reload of 3 without ACK: expiries 3 edges apart, OVERRUN at the second.
      ALARM_PERIODIC = 1'b1;
      do_load(64'd3);
      for (int j = 1; j <= 9; j++) begin
         step(1);
         check("per_irq", 64'(ALARM_IRQ),     64'(j >= 3));
         check("per_ovr", 64'(ALARM_OVERRUN), 64'(j >= 6));
         if (j % 3 == 0) check("per_reload", ALARM_REMAIN, 64'd3);
      end
      do_ack();
      check("per_ack_irq", 64'(ALARM_IRQ),     64'd0);
      check("per_ack_ovr", 64'(ALARM_OVERRUN), 64'd0);
      check("per_ack_rem", ALARM_REMAIN,       64'd2);
      step(2);
      check("per_next_irq", 64'(ALARM_IRQ),     64'd1);
      check("per_next_ovr", 64'(ALARM_OVERRUN), 64'd0);

      // Borrow across the word boundary.
      ALARM_PERIODIC = 1'b0;
      do_load(64'h0000_0001_0000_0000);
      check("borrow_load", ALARM_REMAIN, 64'h0000_0001_0000_0000);
      step(1);
      check("borrow_dec", ALARM_REMAIN, 64'h0000_0000_FFFF_FFFF);

      // LOAD 0 together with ACK: idle, nothing pending.
      ALARM_ACK = 1'b1;
      do_load(64'd0);
      ALARM_ACK = 1'b0;
      check("zero_remain", ALARM_REMAIN,       64'd0);
      check("zero_busy",   64'(ALARM_BUSY),    64'd0);
      check("zero_irq",    64'(ALARM_IRQ),     64'd0);
      check("zero_state",  64'(alarm_state),   64'(M_IDLE));

      // Pause: ENABLE low for 10 cycles after 2 decrements shifts expiry by 10.
      do_load(64'd4);
      step(2);
      check("pause_pre", ALARM_REMAIN, 64'd2);
      ALARM_ENABLE = 1'b0;
      for (int j = 0; j < 10; j++) begin
         step(1);
         check("pause_hold", ALARM_REMAIN,    64'd2);
         check("pause_busy", 64'(ALARM_BUSY), 64'd1);
      end
      ALARM_ENABLE = 1'b1;
      step(1);
      check("pause_resume", ALARM_REMAIN,   64'd1);
      check("pause_noirq",  64'(ALARM_IRQ), 64'd0);
      step(1);
      check("pause_expire", 64'(ALARM_IRQ), 64'd1);
      do_ack();

      // LOAD lands on the expiry edge: no IRQ, new value taken.
      do_load(64'd2);
      step(1);
      check("ldexp_pre", ALARM_REMAIN, 64'd1);
      do_load(64'd7);
      check("ldexp_irq",    64'(ALARM_IRQ), 64'd0);
      check("ldexp_remain", ALARM_REMAIN,   64'd7);

      // ACK lands on a repeat expiry: IRQ stays, OVERRUN stays clear.
      ALARM_PERIODIC = 1'b1;
      do_load(64'd2);
      step(2);
      check("ackexp_first", 64'(ALARM_IRQ), 64'd1);
      step(1);
      do_ack();
      check("ackexp_irq", 64'(ALARM_IRQ),     64'd1);
      check("ackexp_ovr", 64'(ALARM_OVERRUN), 64'd0);
      step(2);
      check("ackexp_next_ovr", 64'(ALARM_OVERRUN), 64'd1);

      // Asynchronous reset between edges while IRQ/OVERRUN are set.
      do_load(64'd50);
      step(3);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("areset_remain", ALARM_REMAIN,       64'd0);
      check("areset_irq",    64'(ALARM_IRQ),     64'd0);
      check("areset_ovr",    64'(ALARM_OVERRUN), 64'd0);
      check("areset_busy",   64'(ALARM_BUSY),    64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(4);
      check("areset_stays_idle", ALARM_REMAIN,    64'd0);
      check("areset_not_busy",   64'(ALARM_BUSY), 64'd0);

      // Random traffic, checked by the model every cycle.
      for (int c = 0; c < 3000; c++) begin
         ALARM_LOAD     = ($urandom_range(0, 15) == 0);
         ALARM_ENABLE   = ($urandom_range(0, 3) != 0);
         ALARM_ACK      = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 31) == 0) ALARM_PERIODIC = ~ALARM_PERIODIC;
         case ($urandom_range(0, 9))
            0:       {ALARM_LOAD_HIGH, ALARM_LOAD_LOW} = 64'd0;
            1:       {ALARM_LOAD_HIGH, ALARM_LOAD_LOW} = {$urandom, $urandom};
            2:       {ALARM_LOAD_HIGH, ALARM_LOAD_LOW} = 64'h0000_0001_0000_0000;
            default: {ALARM_LOAD_HIGH, ALARM_LOAD_LOW} = 64'($urandom_range(1, 8));
         endcase
         step(1);
      end
      ALARM_LOAD = 1'b0;
      ALARM_ACK  = 1'b0;
      step(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
